// File: rtl/instr_mem_loadable_if.sv
// Fetch and program-load bus of the loadable instruction memory.
// master: processor/loader side, slave: the memory.
interface instr_mem_loadable_if #(
  parameter int unsigned DATA_W = 23,
  parameter int unsigned ADDR_W = 5
) ();
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_code;
  logic              prog_start;
  logic              prog_we;
  logic [DATA_W-1:0] prog_data;
  logic              prog_done;
  logic [ADDR_W-1:0] prog_ptr;
  logic              prog_full;
  logic              loading;

  modport master (
    output fetch_req, fetch_addr, prog_start, prog_we, prog_data, prog_done,
    input  fetch_valid, fetch_code, prog_ptr, prog_full, loading
  );

  modport slave (
    input  fetch_req, fetch_addr, prog_start, prog_we, prog_data, prog_done,
    output fetch_valid, fetch_code, prog_ptr, prog_full, loading
  );
endinterface

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: registered fetch port plus a streaming
// program-load port, arbitrated by a RUN/LOAD controller.
// Optional macro INSTR_MEM_BOOT_PROG_EN: with DATA_W==23 and ADDR_W>=4,
// reset fills the memory with a small boot program instead of zeros.
module instr_mem_loadable #(
  parameter int unsigned DATA_W = 23,
  parameter int unsigned ADDR_W = 5
) (
  input logic                  clk,
  input logic                  resetn,
  instr_mem_loadable_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

`ifdef INSTR_MEM_BOOT_PROG_EN
  localparam bit BOOT_EN = (DATA_W == 23) && (ADDR_W >= 4);
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  localparam logic [15:0] BOOT_IMM [8] = '{16'd12, 16'd9, 16'd3, 16'd20,
                                           16'd13, 16'd21, 16'd25, 16'd30};

  typedef enum logic {RUN, LOAD} state_t;

  // Reset image of one word: boot program when enabled, else NOP (0).
  function automatic logic [DATA_W-1:0] reset_word(input int unsigned a);
    logic [22:0] w;
    w = '0;
    if (a < 8) begin
      w = {4'b0001, 3'(a), BOOT_IMM[3'(a)]};
    end else begin
      case (a)
        8:       w = {4'b0010, 3'd0, 3'd4, 13'h0};
        9:       w = {4'b0010, 3'd5, 3'd7, 13'h0};
        10:      w = {4'b0010, 3'd2, 3'd1, 13'h0};
        11:      w = {4'b0011, 3'd3, 3'd0, 13'h0};
        default: w = '0;
      endcase
    end
    return BOOT_EN ? DATA_W'(w) : '0;
  endfunction

  state_t            state_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] ptr_q;
  logic              full_q;
  logic              valid_q;
  logic [DATA_W-1:0] code_q;

  // Controller, load pointer, fetch register and memory array.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
      ptr_q   <= '0;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
      code_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= reset_word(i);
      end
    end else begin
      case (state_q)
        RUN: begin
          valid_q <= bus.fetch_req;
          if (bus.fetch_req) begin
            code_q <= mem_q[bus.fetch_addr];
          end
          if (bus.prog_start) begin
            state_q <= LOAD;
            ptr_q   <= '0;
            full_q  <= 1'b0;
          end
        end
        LOAD: begin
          valid_q <= 1'b0;
          if (bus.prog_start) begin
            ptr_q  <= '0;
            full_q <= 1'b0;
          end else begin
            // A write in the same cycle as prog_done still lands before RUN.
            if (bus.prog_we) begin
              mem_q[ptr_q] <= bus.prog_data;
              ptr_q        <= ptr_q + ADDR_W'(1);
              if (ptr_q == '1) begin
                full_q  <= 1'b1;
                state_q <= RUN;
              end
            end
            if (bus.prog_done) begin
              state_q <= RUN;
            end
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.fetch_valid = valid_q;
  assign bus.fetch_code  = code_q;
  assign bus.prog_ptr    = ptr_q;
  assign bus.prog_full   = full_q;
  assign bus.loading     = (state_q == LOAD);
endmodule
